// File: rtl/xdma_c2h_pkg.sv
// Shared types and constants for the XDMA C2H stream arbiter.
package xdma_c2h_pkg;

  localparam int unsigned C2H_DATA_W = 512;
  localparam int unsigned C2H_KEEP_W = 64;
  localparam int unsigned C2H_DEST_W = 3;   // covers up to 8 sources

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [C2H_DATA_W-1:0] data;
    logic [C2H_KEEP_W-1:0] keep;
    logic                  last;
    logic [C2H_DEST_W-1:0] dest;
  } c2h_beat_t;

endpackage

// File: rtl/xdma_axis_skid.sv
// Two-entry skid buffer for C2H beats: registered output, one-cycle latency,
// full throughput while out_ready is high, in_ready drops only when the spare
// entry is occupied.
module xdma_axis_skid
  import xdma_c2h_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  c2h_beat_t in_beat,
  input  logic      in_valid,
  output logic      in_ready,
  output c2h_beat_t out_beat,
  output logic      out_valid,
  input  logic      out_ready
);

  c2h_beat_t main_q, main_d;
  c2h_beat_t skid_q, skid_d;
  logic      main_vld_q, main_vld_d;
  logic      skid_vld_q, skid_vld_d;
  logic      in_fire;

  assign in_ready  = ~skid_vld_q;
  assign out_beat  = main_q;
  assign out_valid = main_vld_q;

  // Refill the output entry from the spare entry first, otherwise from the input;
  // park an input beat in the spare entry while the output entry is stalled.
  always_comb begin
    in_fire    = in_valid & ~skid_vld_q;
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  // Buffer state; reset empties both entries and clears the payload.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: rtl/xdma_c2h_arbiter.sv
// Packet-atomic round-robin arbiter feeding the XDMA C2H stream.
// Optional statistics counters: define XDMA_C2H_ARB_STATS_EN.
module xdma_c2h_arbiter
  import xdma_c2h_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_SRC*DATA_W-1:0]   src_tdata,
  input  logic [NUM_SRC*DATA_W/8-1:0] src_tkeep,
  input  logic [NUM_SRC-1:0]        src_tlast,
  input  logic [NUM_SRC-1:0]        src_tvalid,
  output logic [NUM_SRC-1:0]        src_tready,
  output logic [DATA_W-1:0]         out_tdata,
  output logic [DATA_W/8-1:0]       out_tkeep,
  output logic                      out_tlast,
  output logic [SRC_W-1:0]          out_tdest,
  output logic                      out_tvalid,
  input  logic                      out_tready
`ifdef XDMA_C2H_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]     stat_pkts,
  output logic [31:0]               stat_stall
`endif
);

  localparam int unsigned KEEP_W = DATA_W / 8;

  arb_state_e           state_q, state_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]     gnt_idx_q, gnt_idx_d;

  logic [2*NUM_SRC-1:0] req_dbl;
  logic                 req_found;
  logic [SRC_W-1:0]     req_pick;
  logic                 gnt_valid;
  logic                 gnt_last;
  logic [DATA_W-1:0]    gnt_data;
  logic [KEEP_W-1:0]    gnt_keep;
  logic [SRC_W-1:0]     gnt_next;
  logic                 beat_acc;

  c2h_beat_t            skid_in;
  c2h_beat_t            skid_out;
  logic                 skid_in_valid;
  logic                 skid_in_ready;
  logic                 skid_unused;

  // Round-robin search: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    int unsigned sum;
    req_dbl   = {src_tvalid, src_tvalid} >> rr_ptr_q;
    req_found = 1'b0;
    req_pick  = rr_ptr_q;
    sum       = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!req_found && req_dbl[k]) begin
        req_found = 1'b1;
        sum       = 32'(rr_ptr_q) + k;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        req_pick  = SRC_W'(sum);
      end
    end
  end

  // Select the locked source's beat and hand it the skid buffer's ready.
  always_comb begin
    gnt_valid  = 1'b0;
    gnt_last   = 1'b0;
    gnt_data   = '0;
    gnt_keep   = '0;
    src_tready = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt_idx_q == SRC_W'(i)) begin
        gnt_valid     = src_tvalid[i];
        gnt_last      = src_tlast[i];
        gnt_data      = src_tdata[i*DATA_W +: DATA_W];
        gnt_keep      = src_tkeep[i*KEEP_W +: KEEP_W];
        src_tready[i] = (state_q == LOCK) & skid_in_ready;
      end
    end
    skid_in_valid = (state_q == LOCK) & gnt_valid;
    beat_acc      = skid_in_valid & skid_in_ready;
    gnt_next      = (gnt_idx_q == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx_q + SRC_W'(1);
    skid_in.data  = C2H_DATA_W'(gnt_data);
    skid_in.keep  = C2H_KEEP_W'(gnt_keep);
    skid_in.last  = gnt_last;
    skid_in.dest  = C2H_DEST_W'(gnt_idx_q);
  end

  // Arbitration next state: grant in IDLE, release the lock on the accepted tlast beat.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          gnt_idx_d = req_pick;
          state_d   = LOCK;
        end
      end
      LOCK: begin
        if (beat_acc && gnt_last) begin
          rr_ptr_d = gnt_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration FSM registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  xdma_axis_skid u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_beat   (skid_in),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .out_beat  (skid_out),
    .out_valid (out_tvalid),
    .out_ready (out_tready)
  );

  assign out_tdata   = skid_out.data[DATA_W-1:0];
  assign out_tkeep   = skid_out.keep[KEEP_W-1:0];
  assign out_tlast   = skid_out.last;
  assign out_tdest   = skid_out.dest[SRC_W-1:0];
  // Upper dest bits are always zero for narrower source counts.
  assign skid_unused = ^skid_out;

`ifdef XDMA_C2H_ARB_STATS_EN
  logic [NUM_SRC*32-1:0] stat_pkts_q, stat_pkts_d;
  logic [31:0]           stat_stall_q, stat_stall_d;

  // Per-source packet count (wrapping) and output stall cycles (saturating).
  always_comb begin
    stat_pkts_d  = stat_pkts_q;
    stat_stall_d = stat_stall_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (beat_acc && gnt_last && gnt_idx_q == SRC_W'(i)) begin
        stat_pkts_d[i*32 +: 32] = stat_pkts_q[i*32 +: 32] + 32'd1;
      end
    end
    if (out_tvalid && !out_tready && stat_stall_q != '1) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_pkts_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_pkts_q  <= stat_pkts_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_pkts  = stat_pkts_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_xdma_c2h_arbiter.sv
// Self-checking bench for xdma_c2h_arbiter: per-source scoreboards filled on
// source handshakes and drained on output handshakes.
module tb_xdma_c2h_arbiter;

  localparam int NS = 4;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int SW = 2;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [NS*DW-1:0] src_tdata = '0;
  logic [NS*KW-1:0] src_tkeep = '0;
  logic [NS-1:0]   src_tlast = '0;
  logic [NS-1:0]   src_tvalid = '0;
  logic [NS-1:0]   src_tready;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic            out_tlast;
  logic [SW-1:0]   out_tdest;
  logic            out_tvalid;
  logic            out_tready = 1'b1;
`ifdef XDMA_C2H_ARB_STATS_EN
  logic [NS*32-1:0] stat_pkts;
  logic [31:0]      stat_stall;
`endif

  always #5 clock = ~clock;

  xdma_c2h_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .src_tdata  (src_tdata),
    .src_tkeep  (src_tkeep),
    .src_tlast  (src_tlast),
    .src_tvalid (src_tvalid),
    .src_tready (src_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tdest  (out_tdest),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready)
`ifdef XDMA_C2H_ARB_STATS_EN
    ,
    .stat_pkts  (stat_pkts),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [SW-1:0] dest;
    logic [7:0]    gap;
  } beat_t;

  beat_t pend_q[NS][$];
  beat_t exp_q[NS][$];
  int    gap_cnt[NS];
  int    out_dest_log[$];
  int    out_cyc_log[$];
  int    acc_src_log[$];
  int    acc_cyc_log[$];

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  int    pkt_serial = 0;
  int    stall_seen = 0;
  int    out_beats = 0;
  logic  prev_stall = 1'b0;
  logic  in_pkt = 1'b0;
  int    owner = 0;
  logic [DW-1:0] st_data;
  logic [KW-1:0] st_keep;
  logic          st_last;
  logic [SW-1:0] st_dest;

  function automatic beat_t mk(int s, int b, logic last, int gap);
    beat_t t;
    t.data = '0;
    t.data[7:0] = 8'(b);
    t.data[15:8] = 8'(s);
    t.data[47:16] = 32'(pkt_serial);
    t.data[DW-1:DW-32] = $urandom();
    t.keep = {$urandom(), $urandom()};
    t.last = last;
    t.dest = SW'(s);
    t.gap = 8'(gap);
    return t;
  endfunction

  task automatic load_pkt(int s, int len, int gap_at, int gap_len);
    if (pend_q[s].size() == 0) gap_cnt[s] = 0;
    for (int b = 0; b < len; b++)
      pend_q[s].push_back(mk(s, b, b == len - 1, (b == gap_at) ? gap_len : 0));
    pkt_serial++;
  endtask

  function automatic logic busy();
    for (int i = 0; i < NS; i++)
      if (pend_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_tb();
    for (int i = 0; i < NS; i++) begin
      pend_q[i].delete();
      exp_q[i].delete();
      gap_cnt[i] = 0;
    end
    out_dest_log.delete();
    out_cyc_log.delete();
    acc_src_log.delete();
    acc_cyc_log.delete();
    prev_stall = 1'b0;
    in_pkt = 1'b0;
    stall_seen = 0;
    out_beats = 0;
    src_tvalid = '0;
    src_tlast = '0;
  endtask

  task automatic do_reset();
    clear_tb();
    rdy_mode = 0;
    out_tready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // One clock: drive at negedge, sample handshakes 2 time units before posedge.
  task automatic step();
    beat_t b;
    int d;
    for (int i = 0; i < NS; i++) begin
      if (pend_q[i].size() != 0 && gap_cnt[i] == 0) begin
        src_tvalid[i] = 1'b1;
        src_tdata[i*DW +: DW] = pend_q[i][0].data;
        src_tkeep[i*KW +: KW] = pend_q[i][0].keep;
        src_tlast[i] = pend_q[i][0].last;
      end else begin
        if (gap_cnt[i] != 0) gap_cnt[i]--;
        src_tvalid[i] = 1'b0;
        src_tlast[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0: out_tready = 1'b1;
      1: out_tready = 1'($urandom_range(0, 1));
      default: out_tready = 1'b0;
    endcase
    #3;
    checks++;
    if ($countones(src_tready) > 1) begin
      failures++;
      $display("FAIL onehot_ready cyc=%0d src_tready=%b required at most one bit", cyc, src_tready);
    end
    for (int i = 0; i < NS; i++) begin
      if (src_tvalid[i] && src_tready[i]) begin
        b = pend_q[i].pop_front();
        exp_q[i].push_back(b);
        acc_src_log.push_back(i);
        acc_cyc_log.push_back(cyc);
        if (pend_q[i].size() != 0) gap_cnt[i] = int'(pend_q[i][0].gap);
      end
    end
    if (prev_stall) begin
      checks++;
      if (!out_tvalid || out_tdata !== st_data || out_tkeep !== st_keep ||
          out_tlast !== st_last || out_tdest !== st_dest) begin
        failures++;
        $display("FAIL stall_stable cyc=%0d valid=%b dest=%0d last=%b data=%h required valid=1 dest=%0d last=%b data=%h",
                 cyc, out_tvalid, out_tdest, out_tlast, out_tdata, st_dest, st_last, st_data);
      end
    end
    if (out_tvalid && out_tready) begin
      d = int'(out_tdest);
      checks++;
      if (exp_q[d].size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat cyc=%0d dest=%0d data=%h required no beat", cyc, d, out_tdata);
      end else begin
        b = exp_q[d].pop_front();
        if (out_tdata !== b.data || out_tkeep !== b.keep || out_tlast !== b.last) begin
          failures++;
          $display("FAIL beat_payload cyc=%0d dest=%0d got last=%b keep=%h data=%h required last=%b keep=%h data=%h",
                   cyc, d, out_tlast, out_tkeep, out_tdata, b.last, b.keep, b.data);
        end
      end
      checks++;
      if (in_pkt && d != owner) begin
        failures++;
        $display("FAIL interleave cyc=%0d dest=%0d required %0d", cyc, d, owner);
      end
      owner = d;
      in_pkt = !out_tlast;
      out_dest_log.push_back(d);
      out_cyc_log.push_back(cyc);
      out_beats++;
    end
    if (out_tvalid && !out_tready) stall_seen++;
    prev_stall = out_tvalid && !out_tready;
    st_data = out_tdata;
    st_keep = out_tkeep;
    st_last = out_tlast;
    st_dest = out_tdest;
    @(negedge clock);
    cyc++;
  endtask

  task automatic drain(int max_cyc, string tag);
    int n = 0;
    while (busy() && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (busy()) begin
      failures++;
      $display("FAIL %s_timeout after %0d cycles got beats still pending required none", tag, n);
    end
  endtask

  task automatic test_reset();
    clear_tb();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (out_tvalid !== 1'b0 || src_tready !== '0 || out_tdata !== '0 || out_tkeep !== '0 ||
        out_tlast !== 1'b0 || out_tdest !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b ready=%b last=%b dest=%0d required all zero",
               out_tvalid, src_tready, out_tlast, out_tdest);
    end
    reset_n = 1'b1;
    cyc = 0;
    repeat (3) step();
    checks++;
    if (out_tvalid !== 1'b0 || src_tready !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got valid=%b ready=%b required 0 and 0", out_tvalid, src_tready);
    end
    load_pkt(1, 1, -1, 0);
    load_pkt(2, 1, -1, 0);
    drain(50, "reset_rr");
    checks++;
    if (out_dest_log.size() != 2 || out_dest_log[0] != 1 || out_dest_log[1] != 2) begin
      failures++;
      $display("FAIL reset_rr_order got n=%0d first=%0d required n=2 order 1,2",
               out_dest_log.size(), (out_dest_log.size() > 0) ? out_dest_log[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int s = 0; s < NS; s++) load_pkt(s, 3, -1, 0);
    drain(200, "rr");
    checks++;
    if (out_dest_log.size() != 12) begin
      failures++;
      $display("FAIL rr_count got %0d required 12", out_dest_log.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (out_dest_log[k] != k / 3) begin
          failures++;
          $display("FAIL rr_dest beat=%0d got %0d required %0d", k, out_dest_log[k], k / 3);
        end
        if (k > 0) begin
          checks++;
          if (out_cyc_log[k] - out_cyc_log[k-1] != ((k % 3 == 0) ? 2 : 1)) begin
            failures++;
            $display("FAIL rr_spacing beat=%0d got %0d required %0d", k,
                     out_cyc_log[k] - out_cyc_log[k-1], (k % 3 == 0) ? 2 : 1);
          end
        end
      end
      checks++;
      if (acc_cyc_log[11] - acc_cyc_log[0] + 2 != 16) begin
        failures++;
        $display("FAIL rr_total_cycles got %0d required 16", acc_cyc_log[11] - acc_cyc_log[0] + 2);
      end
      checks++;
      if (out_cyc_log[0] - acc_cyc_log[0] != 1) begin
        failures++;
        $display("FAIL rr_latency got %0d required 1", out_cyc_log[0] - acc_cyc_log[0]);
      end
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    load_pkt(2, 4, 1, 2);
    step();
    load_pkt(0, 1, -1, 0);
    drain(100, "lock");
    checks++;
    if (acc_src_log.size() != 5 || out_dest_log.size() != 5) begin
      failures++;
      $display("FAIL lock_count got acc=%0d out=%0d required 5 and 5", acc_src_log.size(), out_dest_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (acc_src_log[k] != ((k < 4) ? 2 : 0) || out_dest_log[k] != ((k < 4) ? 2 : 0)) begin
          failures++;
          $display("FAIL lock_order beat=%0d got acc=%0d out=%0d required %0d", k,
                   acc_src_log[k], out_dest_log[k], (k < 4) ? 2 : 0);
        end
      end
      checks++;
      if (acc_cyc_log[1] - acc_cyc_log[0] != 3) begin
        failures++;
        $display("FAIL lock_gap got %0d required 3", acc_cyc_log[1] - acc_cyc_log[0]);
      end
    end
  endtask

  task automatic test_random();
    int total = 0;
    int s, len;
    do_reset();
    rdy_mode = 1;
    for (int p = 0; p < 1000; p++) begin
      s = $urandom_range(0, NS - 1);
      len = $urandom_range(1, 16);
      if (len > 1 && $urandom_range(0, 7) == 0)
        load_pkt(s, len, $urandom_range(1, len - 1), $urandom_range(1, 3));
      else
        load_pkt(s, len, -1, 0);
      total += len;
    end
    drain(60000, "random");
    checks++;
    if (out_beats != total) begin
      failures++;
      $display("FAIL random_beats got %0d required %0d", out_beats, total);
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    load_pkt(1, 1, -1, 0);
    drain(50, "mid_pre");
    rdy_mode = 2;
    acc_src_log.delete();
    load_pkt(2, 5, -1, 0);
    while (acc_src_log.size() < 2 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (out_tvalid !== 1'b1 || acc_src_log.size() != 2) begin
      failures++;
      $display("FAIL mid_prestate got valid=%b accepted=%0d required 1 and 2", out_tvalid, acc_src_log.size());
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_tvalid !== 1'b0 || src_tready !== '0) begin
      failures++;
      $display("FAIL mid_async_reset got valid=%b ready=%b required 0 and 0", out_tvalid, src_tready);
    end
    clear_tb();
    rdy_mode = 0;
    @(negedge clock);
    reset_n = 1'b1;
    load_pkt(3, 3, -1, 0);
    load_pkt(0, 3, -1, 0);
    drain(100, "mid_post");
    checks++;
    if (out_dest_log.size() != 6 || out_dest_log[0] != 0 || out_dest_log[3] != 3) begin
      failures++;
      $display("FAIL mid_next_grant got n=%0d first=%0d required n=6 first=0",
               out_dest_log.size(), (out_dest_log.size() > 0) ? out_dest_log[0] : -1);
    end
  endtask

`ifdef XDMA_C2H_ARB_STATS_EN
  task automatic test_stats();
    int n = 0;
    do_reset();
    for (int p = 0; p < 3; p++) load_pkt(1, 2, -1, 0);
    drain(100, "stats_pkts");
    checks++;
    if (stat_pkts[63:32] !== 32'd3 || stat_pkts[31:0] !== 32'd0) begin
      failures++;
      $display("FAIL stat_pkts got src1=%0d src0=%0d required 3 and 0", stat_pkts[63:32], stat_pkts[31:0]);
    end
    rdy_mode = 2;
    stall_seen = 0;
    load_pkt(0, 2, -1, 0);
    while (stall_seen < 10 && n < 50) begin
      step();
      n++;
    end
    rdy_mode = 0;
    drain(50, "stats_stall");
    checks++;
    if (stat_stall !== 32'd10 || stat_pkts[31:0] !== 32'd1) begin
      failures++;
      $display("FAIL stat_stall got stall=%0d src0=%0d required 10 and 1", stat_stall, stat_pkts[31:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_random();
    test_reset_mid();
`ifdef XDMA_C2H_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
